// File: rtl/alu_issue_ctrl.sv
// Issue/writeback wrapper around a 16-bit combinational ALU: instruction FIFO,
// 8x16 register file with same-edge bypass, one E stage and one W stage.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs1,
  input  logic [2:0]  in_rs2,
  input  logic        in_imm_en,
  input  logic [15:0] in_imm,
  input  logic        stall,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_i0,
  output logic [15:0] alu_i1,
  input  logic [15:0] alu_o,
  input  logic        alu_carry,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        carry_flag,
  input  logic [2:0]  dbg_rsel,
  output logic [15:0] dbg_rdata
);

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        imm_en;
    logic [15:0] imm;
  } instr_t;

  instr_t        fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  instr_t        head;

  logic [15:0]   regs [8];
  logic          ex_valid;
  logic [2:0]    ex_rd;
  logic          w_en;
  logic [15:0]   rs1_val, rs2_val;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !stall;
  assign head     = fifo_mem[rd_ptr];

  // The W write lands on the same edge as the E load, so forward alu_o
  // instead of the not-yet-updated file entry; r0 is never forwarded.
  assign w_en    = ex_valid && (ex_rd != 3'd0);
  assign rs1_val = (w_en && ex_rd == head.rs1) ? alu_o : regs[head.rs1];
  assign rs2_val = (w_en && ex_rd == head.rs2) ? alu_o : regs[head.rs2];

  assign dbg_rdata = regs[dbg_rsel];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                            imm_en: in_imm_en, imm: in_imm};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_op   <= '0;
      alu_i0   <= '0;
      alu_i1   <= '0;
    end else begin
      ex_valid <= pop;
      if (pop) begin
        ex_rd  <= head.rd;
        alu_op <= head.op;
        alu_i0 <= rs1_val;
        alu_i1 <= head.imm_en ? head.imm : rs2_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      carry_flag <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        if (w_en) regs[ex_rd] <= alu_o;
        wb_rd   <= ex_rd;
        wb_data <= alu_o;
        if (alu_op == 3'b000 || alu_op == 3'b001) carry_flag <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a behavioural ALU closes the loop.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
  logic        in_imm_en;
  logic [15:0] in_imm;
  logic        stall;
  logic [2:0]  alu_op;
  logic [15:0] alu_i0, alu_i1, alu_o;
  logic        alu_carry;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        carry_flag;
  logic [2:0]  dbg_rsel;
  logic [15:0] dbg_rdata;

  int vectors = 0;
  int errors  = 0;

  alu_issue_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_en(in_imm_en), .in_imm(in_imm), .stall(stall),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o(alu_o), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .carry_flag(carry_flag), .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Sub carry is the no-borrow carry of i0 + ~i1 + 1.
  always_comb begin
    alu_o     = '0;
    alu_carry = 1'b0;
    case (alu_op)
      3'd0: {alu_carry, alu_o} = {1'b0, alu_i0} + {1'b0, alu_i1};
      3'd1: {alu_carry, alu_o} = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
      3'd2: alu_o = alu_i0 & alu_i1;
      3'd3: alu_o = alu_i0 | alu_i1;
      3'd4: alu_o = alu_i0 << alu_i1[3:0];
      3'd5: alu_o = alu_i0 >> alu_i1[3:0];
      3'd6: alu_o = $signed(alu_i0) >>> alu_i1[3:0];
      default: alu_o = {15'd0, $signed(alu_i0) < $signed(alu_i1)};
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_en = imm_en; in_imm = imm;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    dbg_rsel = sel;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic chk_wb(input string tag, input logic [2:0] rd, input logic [15:0] data);
    chk({tag, "_valid"}, 16'(wb_valid), 16'd1);
    chk({tag, "_rd"}, 16'(wb_rd), 16'(rd));
    chk({tag, "_data"}, wb_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; dbg_rsel = '0;
    set_in(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    #23 reset_n = 1'b1;
    step();
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_wb_valid", 16'(wb_valid), 16'd0);
    chk("rst_carry", 16'(carry_flag), 16'd0);
    chk("rst_alu_i0", alu_i0, 16'h0);

    // add r1 = r0 + 5
    set_in(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("t1_wb_e0", 16'(wb_valid), 16'd0);
    step();
    chk("t1_wb_e1", 16'(wb_valid), 16'd0);
    step();
    chk_wb("t1_wb", 3'd1, 16'h0005);
    chk("t1_carry", 16'(carry_flag), 16'd0);
    chk_reg("t1_r1", 3'd1, 16'h0005);

    // r1 = 0xFFFF; r2 = r1 + r1; r3 = r2 + 1, back to back
    set_in(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF); in_valid = 1'b1;
    step();
    set_in(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000);
    step();
    set_in(3'd0, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0001);
    step(); in_valid = 1'b0;
    chk_wb("t2_a", 3'd1, 16'hFFFF);
    chk("t2_a_carry", 16'(carry_flag), 16'd0);
    step();
    chk_wb("t2_b", 3'd2, 16'hFFFE);
    chk("t2_b_carry", 16'(carry_flag), 16'd1);
    step();
    chk_wb("t2_c", 3'd3, 16'hFFFF);
    chk("t2_c_carry", 16'(carry_flag), 16'd0);
    chk_reg("t2_r2", 3'd2, 16'hFFFE);
    chk_reg("t2_r3", 3'd3, 16'hFFFF);

    // sub r4 = r1 - r1 sets carry; and r5 = r1 & r1 must leave it alone
    set_in(3'd1, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0); in_valid = 1'b1;
    step();
    set_in(3'd2, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0);
    step(); in_valid = 1'b0;
    step();
    chk_wb("t3_sub", 3'd4, 16'h0000);
    chk("t3_sub_carry", 16'(carry_flag), 16'd1);
    step();
    chk_wb("t3_and", 3'd5, 16'hFFFF);
    chk("t3_and_carry", 16'(carry_flag), 16'd1);
    chk_reg("t3_r4", 3'd4, 16'h0000);
    chk_reg("t3_r5", 3'd5, 16'hFFFF);

    // Fill under stall, fifth instruction held off
    stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_ready_fill", 16'(in_ready), 16'd1);
      set_in(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'(k)); in_valid = 1'b1;
      step();
    end
    chk("t4_full", 16'(in_ready), 16'd0);
    set_in(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0005);
    step();
    chk("t4_full_hold", 16'(in_ready), 16'd0);
    chk("t4_no_issue", 16'(wb_valid), 16'd0);
    stall = 1'b0;
    step();
    chk("t4_ready_after_pop", 16'(in_ready), 16'd1);
    chk("t4_wb_h0", 16'(wb_valid), 16'd0);
    step(); in_valid = 1'b0;
    chk_wb("t4_wb1", 3'd6, 16'h0001);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk_wb("t4_wbk", 3'd6, 16'(k));
    end
    step();
    chk_wb("t4_wb5", 3'd7, 16'h0005);
    step();
    chk("t4_idle", 16'(wb_valid), 16'd0);
    chk_reg("t4_r6", 3'd6, 16'h0004);
    chk_reg("t4_r7", 3'd7, 16'h0005);

    // Write to r0 is dropped and never forwarded to the next reader
    set_in(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234); in_valid = 1'b1;
    step();
    set_in(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0010);
    step(); in_valid = 1'b0;
    step();
    chk_wb("t5_r0", 3'd0, 16'h1234);
    chk_reg("t5_r0_file", 3'd0, 16'h0000);
    step();
    chk_wb("t5_rd_r0", 3'd1, 16'h0010);

    // Reset while an instruction sits in E
    set_in(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0007); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_wb_in_rst", 16'(wb_valid), 16'd0);
    for (int r = 0; r < 8; r++) chk_reg("t6_reg_zero", 3'(r), 16'h0000);
    step();
    #3 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_wb", 16'(wb_valid), 16'd0);
    end
    chk("t6_in_ready", 16'(in_ready), 16'd1);
    chk("t6_carry", 16'(carry_flag), 16'd0);
    chk_reg("t6_r2", 3'd2, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
